// File: rtl/cube_face_shader.sv
`default_nettype none
// ============================================================================
// Module   : cube_face_shader
// Purpose  : Pixel stage behind the pyramid cube generators. Resolves the
//            per-cube face hits of the current pixel into one 24-bit RGB
//            colour, tracks which cubes have had their top face visited,
//            counts visited cubes and flags level completion.
//            Two-cycle latency, no stall: every clock advances the pipeline.
// Ports    : i_clk            pixel clock
//            i_reset          asynchronous, active-high reset
//            i_frame_start    1-cycle pulse on the first pixel of a frame
//            i_pixel_valid    face inputs valid this cycle
//            i_left_face      left-face hit, bit i = cube i
//            i_right_face     right-face hit, bit i = cube i
//            i_top_face       top quadrant hits, [4i+3:4i] = cube i
//            i_passage        per-cube passage level (rising edge = visit)
//            i_level_reset    1-cycle pulse, clears all visit state
//            o_rgb            pixel colour (2 cycles after the inputs)
//            o_rgb_valid      i_pixel_valid delayed by 2 cycles
//            o_visited_cnt    number of visited cubes
//            o_level_complete sticky, set once every cube is visited
// Config   : define CUBE_FLASH_EN to make the top faces flash between the
//            two top colours every FLASH_FRAMES frames after completion.
// Revision : 1.0 - initial release
// ============================================================================
module cube_face_shader #(
  parameter int          N_CUBES   = 28,
  parameter logic [23:0] COL_LEFT  = 24'h4A6F8C,
  parameter logic [23:0] COL_RIGHT = 24'h1E2F3C,
  parameter logic [23:0] COL_TOP0  = 24'hC8C8C8,
  parameter logic [23:0] COL_TOP1  = 24'hE0B020,
  parameter logic [23:0] COL_BG    = 24'h000000
`ifdef CUBE_FLASH_EN
  ,
  parameter int          FLASH_FRAMES = 8
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_frame_start,
  input  logic                   i_pixel_valid,
  input  logic [N_CUBES-1:0]     i_left_face,
  input  logic [N_CUBES-1:0]     i_right_face,
  input  logic [4*N_CUBES-1:0]   i_top_face,
  input  logic [N_CUBES-1:0]     i_passage,
  input  logic                   i_level_reset,
  output logic [23:0]            o_rgb,
  output logic                   o_rgb_valid,
  output logic [5:0]             o_visited_cnt,
  output logic                   o_level_complete
);

  localparam int         c_IDX_W      = 6;
  localparam logic [1:0] c_FACE_NONE  = 2'd0;
  localparam logic [1:0] c_FACE_LEFT  = 2'd1;
  localparam logic [1:0] c_FACE_RIGHT = 2'd2;
  localparam logic [1:0] c_FACE_TOP   = 2'd3;

  // --------------------------------------------------------------------------
  // Stage 1: hit resolution
  // --------------------------------------------------------------------------
  logic [N_CUBES-1:0] w_top_hit;
  logic [N_CUBES-1:0] w_any_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_CUBES; gi++) begin : g_hit
      assign w_top_hit[gi] = |i_top_face[4*gi +: 4];
      assign w_any_hit[gi] = i_left_face[gi] | i_right_face[gi] | w_top_hit[gi];
    end
  endgenerate

  logic [1:0]         w_face;
  logic [c_IDX_W-1:0] w_idx;

  // Scan from the highest index down so the lowest hit cube is the last
  // assignment and therefore wins on shared edges.
  always_comb begin
    w_face = c_FACE_NONE;
    w_idx  = '0;
    for (int i = N_CUBES - 1; i >= 0; i--) begin
      if (w_any_hit[i]) begin
        w_idx = c_IDX_W'(i);
        if (w_top_hit[i])        w_face = c_FACE_TOP;
        else if (i_left_face[i]) w_face = c_FACE_LEFT;
        else                     w_face = c_FACE_RIGHT;
      end
    end
  end

  logic [1:0]         r_s1_face;
  logic [c_IDX_W-1:0] r_s1_idx;
  logic               r_s1_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_face  <= c_FACE_NONE;
      r_s1_idx   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_face  <= w_face;
      r_s1_idx   <= w_idx;
      r_s1_valid <= i_pixel_valid;
    end
  end

  // --------------------------------------------------------------------------
  // Visit tracking
  // --------------------------------------------------------------------------
  logic [N_CUBES-1:0] r_passage_d;
  logic [N_CUBES-1:0] r_pending;
  logic [N_CUBES-1:0] r_visited;
  logic [5:0]         r_visited_cnt;
  logic               r_level_complete;

  logic [N_CUBES-1:0] w_rise;
  logic [N_CUBES-1:0] w_new_visits;
  logic [6:0]         w_new_cnt;
  logic [6:0]         w_sum;
  logic [5:0]         w_cnt_next;

  assign w_rise       = i_passage & ~r_passage_d;
  assign w_new_visits = r_pending & ~r_visited;

  always_comb begin
    w_new_cnt = '0;
    for (int i = 0; i < N_CUBES; i++) begin
      w_new_cnt = w_new_cnt + 7'(w_new_visits[i]);
    end
  end

  assign w_sum      = {1'b0, r_visited_cnt} + w_new_cnt;
  assign w_cnt_next = (w_sum > 7'(N_CUBES)) ? 6'(N_CUBES) : w_sum[5:0];

  // The passage history keeps tracking through level_reset so that a
  // passage held high across the reset cannot re-trigger a visit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_passage_d <= '0;
    else         r_passage_d <= i_passage;
  end

  // Visits accumulate in r_pending and are only committed on frame_start so
  // the top colours never change part way through a frame. An edge in the
  // frame_start cycle itself is carried into the next frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending        <= '0;
      r_visited        <= '0;
      r_visited_cnt    <= '0;
      r_level_complete <= 1'b0;
    end else if (i_level_reset) begin
      r_pending        <= '0;
      r_visited        <= '0;
      r_visited_cnt    <= '0;
      r_level_complete <= 1'b0;
    end else begin
      if (i_frame_start) begin
        r_visited     <= r_visited | r_pending;
        r_pending     <= w_rise;
        r_visited_cnt <= w_cnt_next;
      end else begin
        r_pending     <= r_pending | w_rise;
      end
      r_level_complete <= r_level_complete | (r_visited_cnt == 6'(N_CUBES));
    end
  end

  // --------------------------------------------------------------------------
  // Top colour after completion
  // --------------------------------------------------------------------------
  logic [23:0] w_top_done;

`ifdef CUBE_FLASH_EN
  localparam int c_FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [c_FLASH_W-1:0] r_flash_cnt;
  logic                 r_flash_phase;

  // Phase 0 shows COL_TOP1 so the flash starts on the visited colour.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_flash_cnt   <= '0;
      r_flash_phase <= 1'b0;
    end else if (i_level_reset) begin
      r_flash_cnt   <= '0;
      r_flash_phase <= 1'b0;
    end else if (i_frame_start && r_level_complete) begin
      if (r_flash_cnt == c_FLASH_W'(FLASH_FRAMES - 1)) begin
        r_flash_cnt   <= '0;
        r_flash_phase <= ~r_flash_phase;
      end else begin
        r_flash_cnt   <= r_flash_cnt + 1'b1;
      end
    end
  end

  assign w_top_done = r_flash_phase ? COL_TOP0 : COL_TOP1;
`else
  assign w_top_done = COL_TOP1;
`endif

  // --------------------------------------------------------------------------
  // Stage 2: colour lookup
  // --------------------------------------------------------------------------
  logic [63:0] w_visited_ext;
  logic [23:0] w_colour;
  logic [23:0] r_rgb;
  logic        r_rgb_valid;

  // Widened so the 6-bit cube index always addresses a real bit.
  assign w_visited_ext = {{(64 - N_CUBES){1'b0}}, r_visited};

  always_comb begin
    w_colour = COL_BG;
    case (r_s1_face)
      c_FACE_LEFT:  w_colour = COL_LEFT;
      c_FACE_RIGHT: w_colour = COL_RIGHT;
      c_FACE_TOP: begin
        if (r_level_complete)              w_colour = w_top_done;
        else if (w_visited_ext[r_s1_idx])  w_colour = COL_TOP1;
        else                               w_colour = COL_TOP0;
      end
      default:      w_colour = COL_BG;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb       <= w_colour;
      r_rgb_valid <= r_s1_valid;
    end
  end

  assign o_rgb            = r_rgb;
  assign o_rgb_valid      = r_rgb_valid;
  assign o_visited_cnt    = r_visited_cnt;
  assign o_level_complete = r_level_complete;

endmodule
`default_nettype wire

// File: tb/tb_cube_face_shader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cube_face_shader
// Purpose  : Self-checking bench for cube_face_shader. A behavioural model
//            of visits, commits and colours predicts every output; stimulus
//            is partly directed, partly $urandom driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cube_face_shader;

  localparam int          N         = 28;
  localparam int          FLASH     = 8;
  localparam logic [23:0] C_LEFT    = 24'h4A6F8C;
  localparam logic [23:0] C_RIGHT   = 24'h1E2F3C;
  localparam logic [23:0] C_TOP0    = 24'hC8C8C8;
  localparam logic [23:0] C_TOP1    = 24'hE0B020;
  localparam logic [23:0] C_BG      = 24'h000000;

  logic             clk = 1'b0;
  logic             i_reset;
  logic             i_frame_start;
  logic             i_pixel_valid;
  logic [N-1:0]     i_left_face;
  logic [N-1:0]     i_right_face;
  logic [4*N-1:0]   i_top_face;
  logic [N-1:0]     i_passage;
  logic             i_level_reset;
  logic [23:0]      o_rgb;
  logic             o_rgb_valid;
  logic [5:0]       o_visited_cnt;
  logic             o_level_complete;

  cube_face_shader dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_frame_start    (i_frame_start),
    .i_pixel_valid    (i_pixel_valid),
    .i_left_face      (i_left_face),
    .i_right_face     (i_right_face),
    .i_top_face       (i_top_face),
    .i_passage        (i_passage),
    .i_level_reset    (i_level_reset),
    .o_rgb            (o_rgb),
    .o_rgb_valid      (o_rgb_valid),
    .o_visited_cnt    (o_visited_cnt),
    .o_level_complete (o_level_complete)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  bit [N-1:0] m_vis, m_pend, m_pd;
  int         m_cnt, m_fcount;
  bit         m_complete;
  logic [23:0] prev_rgb, exp_rgb;
  logic        prev_valid, exp_valid;

  task automatic reset_model();
    m_vis = '0; m_pend = '0; m_pd = '0;
    m_cnt = 0; m_fcount = 0; m_complete = 1'b0;
    prev_rgb = C_BG; prev_valid = 1'b0;
    exp_rgb  = C_BG; exp_valid  = 1'b0;
  endtask

  function automatic logic [23:0] top_colour(int i);
`ifdef CUBE_FLASH_EN
    if (m_complete) return (((m_fcount / FLASH) % 2) == 0) ? C_TOP1 : C_TOP0;
`endif
    return m_vis[i] ? C_TOP1 : C_TOP0;
  endfunction

  function automatic logic [23:0] pixel_colour(logic [N-1:0] l, logic [N-1:0] r,
                                               logic [4*N-1:0] t);
    for (int i = 0; i < N; i++) begin
      if (|t[4*i +: 4]) return top_colour(i);
      if (l[i])         return C_LEFT;
      if (r[i])         return C_RIGHT;
    end
    return C_BG;
  endfunction

  task automatic model_update();
    bit [N-1:0] rise;
    int old_cnt;
    bit old_complete;
    rise = i_passage & ~m_pd;
    old_cnt = m_cnt;
    old_complete = m_complete;
    if (i_level_reset) begin
      m_vis = '0; m_pend = '0; m_cnt = 0; m_complete = 1'b0; m_fcount = 0;
    end else begin
      if (i_frame_start) begin
        for (int i = 0; i < N; i++) begin
          if (m_pend[i] && !m_vis[i]) begin
            m_vis[i] = 1'b1;
            if (m_cnt < N) m_cnt++;
          end
        end
        m_pend = rise;
      end else begin
        m_pend = m_pend | rise;
      end
      if (old_cnt == N) m_complete = 1'b1;
      if (old_complete && i_frame_start) m_fcount++;
    end
    m_pd = i_passage;
  endtask

  // One clock: capture inputs, advance the model, then line the expectation
  // up with the two-cycle pipeline.
  task automatic tick();
    logic [N-1:0]   l, r;
    logic [4*N-1:0] t;
    logic           pv;
    logic [23:0]    c;
    l = i_left_face; r = i_right_face; t = i_top_face; pv = i_pixel_valid;
    model_update();
    c = pixel_colour(l, r, t);
    @(posedge clk);
    #1;
    exp_rgb = prev_rgb; exp_valid = prev_valid;
    prev_rgb = c; prev_valid = pv;
  endtask

  task automatic clear_faces();
    i_left_face = '0; i_right_face = '0; i_top_face = '0;
  endtask

  task automatic random_pixel();
    int k;
    clear_faces();
    i_pixel_valid = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 3);
    for (int j = 0; j < k; j++) begin
      case ($urandom_range(0, 2))
        0: i_left_face[$urandom_range(0, N-1)] = 1'b1;
        1: i_right_face[$urandom_range(0, N-1)] = 1'b1;
        default: i_top_face[$urandom_range(0, 4*N-1)] = 1'b1;
      endcase
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_faces();
    i_pixel_valid = 1'b1;
    i_left_face[0] = 1'b1;
    tick(); tick();
    // Asynchronous assertion mid-cycle.
    i_reset = 1'b1;
    #1;
    n_checks++;
    if (o_rgb !== 24'h0 || o_rgb_valid !== 1'b0)
      $display("FAIL reset_async: rgb=%h valid=%b, expected 000000/0", o_rgb, o_rgb_valid);
    else n_pass++;
    n_checks++;
    if (o_visited_cnt !== 6'd0 || o_level_complete !== 1'b0)
      $display("FAIL reset_state: cnt=%0d complete=%b, expected 0/0", o_visited_cnt, o_level_complete);
    else n_pass++;
    @(posedge clk); #1;
    i_reset = 1'b0;
    reset_model();
    tick();
    n_checks++;
    if (o_rgb !== C_BG || o_rgb_valid !== 1'b0)
      $display("FAIL reset_flush: rgb=%h valid=%b, expected %h/0", o_rgb, o_rgb_valid, C_BG);
    else n_pass++;
    tick();
    n_checks++;
    if (o_rgb !== C_LEFT || o_rgb_valid !== 1'b1 || exp_rgb !== C_LEFT)
      $display("FAIL reset_release: rgb=%h valid=%b, expected %h/1", o_rgb, o_rgb_valid, C_LEFT);
    else n_pass++;
  endtask

  task automatic test_priority();
    clear_faces();
    i_pixel_valid = 1'b1;
    i_left_face[3] = 1'b1;
    i_top_face[4*1+2] = 1'b1;
    tick();
    clear_faces();
    tick();
    n_checks++;
    if (o_rgb !== C_TOP0 || o_rgb !== exp_rgb)
      $display("FAIL priority_top: rgb=%h, expected %h", o_rgb, C_TOP0);
    else n_pass++;
    tick();
    n_checks++;
    if (o_rgb !== C_BG || o_rgb !== exp_rgb)
      $display("FAIL priority_none: rgb=%h, expected %h", o_rgb, C_BG);
    else n_pass++;
    // Same cube: top beats left beats right.
    i_left_face[4] = 1'b1; i_right_face[4] = 1'b1;
    tick();
    i_left_face[4] = 1'b0;
    tick();
    n_checks++;
    if (o_rgb !== C_LEFT) $display("FAIL priority_left: rgb=%h, expected %h", o_rgb, C_LEFT);
    else n_pass++;
    tick();
    n_checks++;
    if (o_rgb !== C_RIGHT) $display("FAIL priority_right: rgb=%h, expected %h", o_rgb, C_RIGHT);
    else n_pass++;
    clear_faces();
  endtask

  task automatic test_random_pixels();
    for (int n = 0; n < 40; n++) begin
      random_pixel();
      tick();
      n_checks++;
      if (o_rgb !== exp_rgb || o_rgb_valid !== exp_valid)
        $display("FAIL rand_pixel[%0d]: rgb=%h valid=%b, expected %h/%b",
                 n, o_rgb, o_rgb_valid, exp_rgb, exp_valid);
      else n_pass++;
    end
    clear_faces();
    i_pixel_valid = 1'b1;
  endtask

  task automatic test_deferred_commit();
    i_passage = '0;
    tick();
    clear_faces();
    i_top_face[4*5] = 1'b1;
    i_passage[5] = 1'b1;
    tick();
    tick();
    n_checks++;
    if (o_rgb !== C_TOP0 || o_visited_cnt !== 6'd0 || exp_rgb !== C_TOP0)
      $display("FAIL defer_midframe: rgb=%h cnt=%0d, expected %h/0", o_rgb, o_visited_cnt, C_TOP0);
    else n_pass++;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    n_checks++;
    if (o_visited_cnt !== 6'd1) $display("FAIL defer_cnt: cnt=%0d, expected 1", o_visited_cnt);
    else n_pass++;
    tick();
    n_checks++;
    if (o_rgb !== C_TOP1 || exp_rgb !== C_TOP1)
      $display("FAIL defer_commit: rgb=%h, expected %h", o_rgb, C_TOP1);
    else n_pass++;
  endtask

  task automatic test_revisit();
    for (int f = 0; f < 2; f++) begin
      i_passage[5] = 1'b0; tick();
      i_passage[5] = 1'b1; tick();
      i_frame_start = 1'b1; tick();
      i_frame_start = 1'b0; tick();
      n_checks++;
      if (o_visited_cnt !== 6'd1 || m_cnt != 1)
        $display("FAIL revisit[%0d]: cnt=%0d, expected 1", f, o_visited_cnt);
      else n_pass++;
    end
    // Edge in the frame_start cycle commits one frame later.
    i_passage[6] = 1'b1; i_frame_start = 1'b1; tick();
    i_frame_start = 1'b0; tick();
    n_checks++;
    if (o_visited_cnt !== 6'd1) $display("FAIL edge_at_fs: cnt=%0d, expected 1", o_visited_cnt);
    else n_pass++;
    i_frame_start = 1'b1; tick();
    i_frame_start = 1'b0;
    n_checks++;
    if (o_visited_cnt !== 6'd2) $display("FAIL edge_next_frame: cnt=%0d, expected 2", o_visited_cnt);
    else n_pass++;
  endtask

  task automatic test_completion();
    i_passage = '1; tick();
    i_frame_start = 1'b1; tick();
    i_frame_start = 1'b0;
    n_checks++;
    if (o_visited_cnt !== 6'(N) || o_level_complete !== 1'b0)
      $display("FAIL complete_cnt: cnt=%0d complete=%b, expected %0d/0", o_visited_cnt, o_level_complete, N);
    else n_pass++;
    tick();
    n_checks++;
    if (o_level_complete !== 1'b1 || o_visited_cnt !== 6'(N))
      $display("FAIL complete_flag: cnt=%0d complete=%b, expected %0d/1", o_visited_cnt, o_level_complete, N);
    else n_pass++;
    i_passage[0] = 1'b0; tick();
    i_passage[0] = 1'b1; i_level_reset = 1'b1; tick();
    i_level_reset = 1'b0;
    n_checks++;
    if (o_visited_cnt !== 6'd0 || o_level_complete !== 1'b0)
      $display("FAIL level_reset: cnt=%0d complete=%b, expected 0/0", o_visited_cnt, o_level_complete);
    else n_pass++;
    clear_faces();
    i_top_face[0] = 1'b1;
    i_frame_start = 1'b1; tick();
    i_frame_start = 1'b0; tick(); tick();
    n_checks++;
    if (o_rgb !== C_TOP0 || o_visited_cnt !== 6'd0 || exp_rgb !== C_TOP0)
      $display("FAIL lr_discard: rgb=%h cnt=%0d, expected %h/0", o_rgb, o_visited_cnt, C_TOP0);
    else n_pass++;
  endtask

  task automatic test_flash();
    i_passage = '0; tick();
    i_passage = '1; tick();
    i_frame_start = 1'b1; tick();
    i_frame_start = 1'b0; tick();
    for (int f = 0; f < 20; f++) begin
      clear_faces();
      i_top_face[4*$urandom_range(0, N-1) + $urandom_range(0, 3)] = 1'b1;
      i_frame_start = 1'b1; tick();
      i_frame_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick();
        n_checks++;
        if (o_rgb !== exp_rgb)
          $display("FAIL flash[%0d.%0d]: rgb=%h, expected %h", f, c, o_rgb, exp_rgb);
        else n_pass++;
      end
`ifndef CUBE_FLASH_EN
      n_checks++;
      if (o_rgb !== C_TOP1) $display("FAIL no_flash[%0d]: rgb=%h, expected %h", f, o_rgb, C_TOP1);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_random_visits();
    for (int n = 0; n < 200; n++) begin
      random_pixel();
      if ($urandom_range(0, 1) == 1) i_passage[$urandom_range(0, N-1)] ^= 1'b1;
      i_frame_start = ($urandom_range(0, 7) == 0);
      i_level_reset = ($urandom_range(0, 59) == 0);
      tick();
      n_checks++;
      if (o_rgb !== exp_rgb || o_rgb_valid !== exp_valid ||
          o_visited_cnt !== 6'(m_cnt) || o_level_complete !== m_complete)
        $display("FAIL rand_visit[%0d]: rgb=%h v=%b cnt=%0d c=%b, expected %h/%b/%0d/%b",
                 n, o_rgb, o_rgb_valid, o_visited_cnt, o_level_complete,
                 exp_rgb, exp_valid, m_cnt, m_complete);
      else n_pass++;
    end
    i_frame_start = 1'b0;
    i_level_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_frame_start = 1'b0;
    i_pixel_valid = 1'b0;
    i_passage = '0;
    i_level_reset = 1'b0;
    clear_faces();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    reset_model();

    test_reset();
    test_priority();
    test_random_pixels();
    test_deferred_commit();
    test_revisit();
    test_completion();
    test_flash();
    test_random_visits();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
